// File: rtl/rv32i_types.sv
// Shared RV32 execute-stage types.
// Holds the M-extension op encodings used by decode and the iterative units.
package rv32i_types;

  typedef enum logic [1:0] {
    mul    = 2'b00,
    mulh   = 2'b01,
    mulhsu = 2'b10,
    mulhu  = 2'b11
  } mul_ops;

  typedef enum logic [1:0] {
    div  = 2'b00,
    divu = 2'b01,
    rem  = 2'b10,
    remu = 2'b11
  } div_ops;

  // funct3 000..011 select the multiply ops directly
  function automatic mul_ops mul_decode(input logic [2:0] funct3);
    return mul_ops'(funct3[1:0]);
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Start/done handshake shared with the divider; fixed WIDTH+2 cycle latency.
module mul_iter
  import rv32i_types::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  input  mul_ops           mulop,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE, BUSY, CLEANUP, DONE
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     count;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]     b;
  logic                 neg;
  mul_ops               op;
  logic [2*WIDTH:0]     cap;
  logic [2*WIDTH-1:0]   fixed;
  logic [WIDTH-1:0]     sel;

  // {negate, |rs1|, |rs2|} with signedness chosen by the op
  function automatic logic [2*WIDTH:0] prep(
    input mul_ops           o,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic             sx, sy;
    logic [WIDTH-1:0] mx, my;
    sx = (o != mulhu) & x[WIDTH-1];
    sy = ((o == mul) | (o == mulh)) & y[WIDTH-1];
    mx = sx ? -x : x;
    my = sy ? -y : y;
    return {sx ^ sy, mx, my};
  endfunction

  assign cap   = prep(mulop, multiplicand, multiplier);
  assign fixed = neg ? -acc : acc;
  assign sel   = (op == mul) ? fixed[WIDTH-1:0]
                             : fixed[2*WIDTH-1:WIDTH];
  assign done  = (state == DONE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = BUSY;
      BUSY:    if (count == '0) state_n = CLEANUP;
      CLEANUP: state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      a_sh   <= '0;
      b      <= '0;
      neg    <= 1'b0;
      op     <= mul;
      result <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: if (start) begin
          neg   <= cap[2*WIDTH];
          a_sh  <= {{WIDTH{1'b0}}, cap[2*WIDTH-1:WIDTH]};
          b     <= cap[WIDTH-1:0];
          acc   <= '0;
          count <= CNT_W'(WIDTH);
          op    <= mulop;
        end
        BUSY: if (count != '0) begin
          if (b[0]) acc <= acc + a_sh;
          a_sh  <= a_sh << 1;
          b     <= b >> 1;
          count <= count - 1'b1;
        end
        CLEANUP: begin
          acc    <= fixed;
          result <= sel;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: vector table, corner sequences,
// and a back-to-back run against a signed 64-bit reference product.
module tb_mul_iter;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  mul_ops      mulop = mul;
  logic        start = 1'b0;
  logic [31:0] result;
  logic        done;

  mul_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .mulop(mulop), .start(start),
    .result(result), .done(done)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;
  int ndone = 0;
  int done_cyc = 0;
  logic [31:0] q[$];

  typedef struct {
    mul_ops      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (done) begin
      ndone++;
      done_cyc = cyc;
      if (q.size() == 0) begin
        ncmp++;
        nerr++;
        $display("FAIL extra_done: got done at cycle %0d expected none", cyc);
      end else begin
        check("result", {32'b0, result}, {32'b0, q.pop_front()});
      end
    end
  end

  function automatic logic [31:0] model(input mul_ops o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    sa = (o == mulhu) ? {32'b0, a} : {{32{a[31]}}, a};
    sb = (o == mul || o == mulh) ? {{32{b[31]}}, b} : {32'b0, b};
    p = sa * sb;
    return (o == mul) ? p[31:0] : p[63:32];
  endfunction

  task automatic do_op(input mul_ops op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input bit scramble);
    int s, d0;
    bit got;
    @(negedge clk);
    mulop = op; multiplicand = a; multiplier = b; start = 1'b1;
    q.push_back(exp);
    s = cyc + 1;
    d0 = ndone;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (ndone != d0) begin
        got = 1'b1;
        break;
      end
      if (scramble) begin
        multiplicand = $urandom;
        multiplier = $urandom;
        mulop = mul_ops'($urandom_range(0, 3));
        start = (i == 10);
      end
    end
    start = 1'b0;
    check("latency", got ? 64'(done_cyc - s) : 64'hdead, 64'd34);
    repeat (3) @(negedge clk);
    check("one_done", 64'(ndone - d0), 64'd1);
    check("result_hold", {32'b0, result}, {32'b0, exp});
  endtask

  task automatic pick(output mul_ops o, output logic [31:0] a,
                      output logic [31:0] b);
    o = mul_ops'($urandom_range(0, 3));
    a = $urandom;
    b = $urandom;
    if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
    if ($urandom_range(0, 7) == 0) b = '0;
  endtask

  task automatic b2b(input int n);
    int d0, d_start, last;
    bit got;
    mul_ops o;
    logic [31:0] a, b;
    last = 0;
    d_start = ndone;
    @(negedge clk);
    pick(o, a, b);
    mulop = o; multiplicand = a; multiplier = b; start = 1'b1;
    q.push_back(model(o, a, b));
    for (int k = 0; k < n; k++) begin
      d0 = ndone;
      got = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (ndone != d0) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        check("b2b_timeout", 64'd0, 64'd1);
        break;
      end
      if (k > 0) check("b2b_spacing", 64'(done_cyc - last), 64'd36);
      last = done_cyc;
      if (k < n - 1) begin
        pick(o, a, b);
        mulop = o; multiplicand = a; multiplier = b;
        q.push_back(model(o, a, b));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("b2b_count", 64'(ndone - d_start), 64'(n));
    check("queue_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    vecs[0] = '{mul,    32'd7,         32'd6,         32'h0000_002A};
    vecs[1] = '{mul,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1};
    vecs[2] = '{mulh,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[3] = '{mulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4] = '{mulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[5] = '{mul,    32'd0,         32'd0,         32'h0000_0000};
    vecs[6] = '{mulh,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{mulhu,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
    vecs[8] = '{mulh,   32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000};
    vecs[9] = '{mulhsu, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};

    repeat (3) @(negedge clk);
    check("reset_result", {32'b0, result}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_done", {63'b0, done}, 64'd0);

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);

    // operands scrambled and start re-pulsed while busy
    do_op(mulhsu, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 1'b1);
    do_op(mul, 32'd12345, 32'd1000, 32'd12345000, 1'b1);

    // asynchronous abort mid-operation
    @(negedge clk);
    mulop = mulhu; multiplicand = 32'hFFFF_FFFF;
    multiplier = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    d0 = ndone;
    #2 rst = 1'b0;
    #1;
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_result", {32'b0, result}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(ndone - d0), 64'd0);
    do_op(mulhu, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0);

    b2b(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
